// File: rtl/memory_issue_pkg.sv
// Shared definitions for the data-memory issue/receive pair: FSM state
// encoding and access-size codes.
package memory_issue_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  // Size code 3 has no wider access behind it, so it behaves as a word.
  function automatic logic [1:0] eff_size(input logic [1:0] log2_bytes);
    return (log2_bytes == 2'd3) ? SIZE_WORD : log2_bytes;
  endfunction

endpackage

// File: rtl/memory_issue_if.sv
// Memory request port: the issue side is the master, the memory the slave.
interface memory_issue_if #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDRESS_BITS = 32
);
  localparam int NUM_BYTES = DATA_WIDTH / 8;

  logic                    memory_read;
  logic                    memory_write;
  logic [NUM_BYTES-1:0]    memory_byte_en;
  logic [ADDRESS_BITS-1:0] memory_address_out;
  logic [DATA_WIDTH-1:0]   memory_data_out;
  logic                    memory_ready;

  modport master (
    output memory_read, memory_write, memory_byte_en,
           memory_address_out, memory_data_out,
    input  memory_ready
  );

  modport slave (
    input  memory_read, memory_write, memory_byte_en,
           memory_address_out, memory_data_out,
    output memory_ready
  );
endinterface

// File: rtl/memory_issue_store_align.sv
// Combinational lane logic: byte enables, store-data replication and the
// natural-alignment check for one request.
module memory_issue_store_align
  import memory_issue_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_BYTES      = DATA_WIDTH / 8,
  parameter int LOG2_NUM_BYTES = $clog2(NUM_BYTES)
) (
  input  logic [LOG2_NUM_BYTES-1:0] log2_bytes,
  input  logic [LOG2_NUM_BYTES-1:0] addr_low,
  input  logic [DATA_WIDTH-1:0]     data,
  output logic [NUM_BYTES-1:0]      byte_en,
  output logic [DATA_WIDTH-1:0]     data_out,
  output logic                      misaligned
);

  // Decode size into lane enables, replicated data and the alignment fault.
  always_comb begin
    byte_en    = '1;
    data_out   = data;
    misaligned = 1'b0;
    case (eff_size(log2_bytes))
      SIZE_BYTE: begin
        byte_en  = NUM_BYTES'(1) << addr_low;
        data_out = {NUM_BYTES{data[7:0]}};
      end
      SIZE_HALF: begin
        byte_en    = NUM_BYTES'(2'b11) << {addr_low[LOG2_NUM_BYTES-1:1], 1'b0};
        data_out   = {(NUM_BYTES/2){data[15:0]}};
        misaligned = addr_low[0];
      end
      default: begin
        byte_en    = '1;
        data_out   = data;
        misaligned = |addr_low;
      end
    endcase
  end

endmodule

// File: rtl/memory_issue.sv
// Issue side of the data-memory interface: accepts load/store requests,
// holds each on the memory port until accepted, and registers the load
// descriptor so memory_receive sees it in step with the returned data.
module memory_issue
  import memory_issue_pkg::*;
#(
  parameter int CORE            = 0,
  parameter int DATA_WIDTH      = 32,
  parameter int ADDRESS_BITS    = 32,
  parameter int NUM_BYTES       = DATA_WIDTH / 8,
  parameter int LOG2_NUM_BYTES  = $clog2(NUM_BYTES),
  parameter int SCAN_CYCLES_MIN = 0,
  parameter int SCAN_CYCLES_MAX = 1000
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      req_valid,
  input  logic                      load,
  input  logic                      store,
  input  logic [LOG2_NUM_BYTES-1:0] log2_bytes,
  input  logic                      unsigned_load,
  input  logic [ADDRESS_BITS-1:0]   address_in,
  input  logic [DATA_WIDTH-1:0]     store_data_in,
  output logic                      issue_stall,
  memory_issue_if.master            mem,
  output logic [LOG2_NUM_BYTES-1:0] receive_log2_bytes,
  output logic                      receive_unsigned,
  output logic [ADDRESS_BITS-1:0]   receive_address,
  output logic                      misaligned,
  output logic [ADDRESS_BITS-1:0]   misaligned_address,
  input  logic                      scan
);

  state_t                  state;
  logic [NUM_BYTES-1:0]    align_be;
  logic [DATA_WIDTH-1:0]   align_data;
  logic                    align_mis;
  logic                    accept;
  int                      cycle_count;

  memory_issue_store_align #(
    .DATA_WIDTH     (DATA_WIDTH),
    .NUM_BYTES      (NUM_BYTES),
    .LOG2_NUM_BYTES (LOG2_NUM_BYTES)
  ) u_store_align (
    .log2_bytes (log2_bytes),
    .addr_low   (address_in[LOG2_NUM_BYTES-1:0]),
    .data       (store_data_in),
    .byte_en    (align_be),
    .data_out   (align_data),
    .misaligned (align_mis)
  );

  // Stall depends only on the held request and memory, never on req_valid.
  assign issue_stall = (state == WAIT) && !mem.memory_ready;
  assign accept      = req_valid && (load || store) && !issue_stall;

  // Request FSM and registered memory-port outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state                  <= IDLE;
      mem.memory_read        <= 1'b0;
      mem.memory_write       <= 1'b0;
      mem.memory_byte_en     <= '0;
      mem.memory_address_out <= '0;
      mem.memory_data_out    <= '0;
      receive_log2_bytes     <= '0;
      receive_unsigned       <= 1'b0;
      receive_address        <= '0;
      misaligned             <= 1'b0;
      misaligned_address     <= '0;
    end else begin
      misaligned <= 1'b0;
      if (accept && !align_mis) begin
        // Store wins when both load and store are raised.
        state                  <= WAIT;
        mem.memory_read        <= load && !store;
        mem.memory_write       <= store;
        mem.memory_byte_en     <= align_be;
        mem.memory_address_out <= address_in;
        mem.memory_data_out    <= store ? align_data : '0;
        receive_log2_bytes     <= eff_size(log2_bytes);
        receive_unsigned       <= unsigned_load;
        receive_address        <= address_in;
      end else if (accept) begin
        // Faulting request: nothing issued, descriptor left untouched.
        state              <= IDLE;
        mem.memory_read    <= 1'b0;
        mem.memory_write   <= 1'b0;
        misaligned         <= 1'b1;
        misaligned_address <= address_in;
      end else if (state == WAIT && mem.memory_ready) begin
        state            <= IDLE;
        mem.memory_read  <= 1'b0;
        mem.memory_write <= 1'b0;
      end
    end
  end

  // Free-running cycle counter that gates the scan window.
  always_ff @(posedge clock) begin
    if (reset) cycle_count <= 0;
    else       cycle_count <= cycle_count + 1;
  end

`ifndef SYNTHESIS
  // Debug trace of the memory port while scan is enabled.
  always_ff @(posedge clock) begin
    if (scan && cycle_count >= SCAN_CYCLES_MIN && cycle_count <= SCAN_CYCLES_MAX)
      $display("core %0d cycle %0d memory_issue state=%0d rd=%0b wr=%0b be=%h addr=%h data=%h",
               CORE, cycle_count, state, mem.memory_read, mem.memory_write,
               mem.memory_byte_en, mem.memory_address_out, mem.memory_data_out);
  end
`endif

endmodule

// File: doc/memory_issue.md
Name: memory_issue

Overview:
- Issue side of the data-memory interface; the counterpart of memory_receive.
- Takes load/store requests from execute and aligns store data to the byte lanes.
- Generates byte enables, checks alignment, and holds each request on the memory port until the memory accepts it.
- Registers the load descriptor (log2_bytes, unsigned_load, address) so memory_receive gets it in step with the returned data.

Parameters:
- CORE, 0, core index printed in scan output
- DATA_WIDTH, 32, data bus width
- ADDRESS_BITS, 32, address width
- NUM_BYTES, DATA_WIDTH/8, byte lanes
- LOG2_NUM_BYTES, log2(NUM_BYTES), width of log2_bytes
- SCAN_CYCLES_MIN, 0, first cycle of scan printing
- SCAN_CYCLES_MAX, 1000, last cycle of scan printing

Ports:
- clock  in  1  single clock; all state changes on posedge
- reset  in  1  synchronous, active-high
- req_valid  in  1  execute presents a request
- load  in  1  request is a load
- store  in  1  request is a store (wins over load if both high)
- log2_bytes  in  LOG2_NUM_BYTES  access size: 0 byte, 1 half, 2 word; 3 treated as word
- unsigned_load  in  1  zero-extend the load result
- address_in  in  ADDRESS_BITS  byte address
- store_data_in  in  DATA_WIDTH  store data, right-justified
- issue_stall  out  1  request not accepted this cycle; upstream must hold its inputs
- memory_read  out  1  load request to memory
- memory_write  out  1  store request to memory
- memory_byte_en  out  NUM_BYTES  active byte lanes
- memory_address_out  out  ADDRESS_BITS  full byte address
- memory_data_out  out  DATA_WIDTH  lane-replicated store data
- memory_ready  in  1  memory accepts the presented request on this posedge
- receive_log2_bytes  out  LOG2_NUM_BYTES  descriptor for memory_receive
- receive_unsigned  out  1  descriptor for memory_receive
- receive_address  out  ADDRESS_BITS  descriptor for memory_receive
- misaligned  out  1  one-cycle pulse on a misaligned request
- misaligned_address  out  ADDRESS_BITS  address of the faulting request
- scan  in  1  enables $display of state within the scan window

Behaviour:
- Reset (synchronous): every output and register goes to 0, FSM to IDLE. This applies in every state, including WAIT, and takes effect at the first posedge with reset high. No request is ever re-issued after reset.
- States:
  - IDLE: no request on the memory port.
  - WAIT: a request is registered on the memory port.
- Acceptance: a request is accepted when req_valid & (load|store) & !issue_stall.
- issue_stall = (state==WAIT) & !memory_ready. It is combinational and has no path from req_valid.
- Alignment check: misaligned when address_in[k-1:0] != 0, where k = effective log2_bytes.
- Accepted and aligned: on the next posedge, register memory_read/memory_write, memory_byte_en, memory_address_out, memory_data_out and the receive_* descriptor; go to WAIT. Latency is 1 cycle from accept to the request appearing on the port.
- Accepted and misaligned:
  - Nothing is issued.
  - misaligned = 1 and misaligned_address = address_in for exactly 1 cycle.
  - The FSM stays in, or returns to, IDLE.
  - receive_* registers are unchanged.
- WAIT with memory_ready = 0: all memory_* outputs hold stable.
- WAIT with memory_ready = 1:
  - If a new aligned request is accepted the same cycle, it is loaded back-to-back and the FSM stays in WAIT (full throughput, 1 request/cycle).
  - Otherwise memory_read/memory_write go to 0 and the FSM returns to IDLE. Address, data and byte_en may hold their last values.
- Byte enables:
  - byte: 1 << addr[1:0]
  - half: 2'b11 << {addr[1],1'b0}
  - word: all ones
  - Loads drive the same enables as stores.
- Store data lane replication:
  - byte: {NUM_BYTES{d[7:0]}}
  - half: {NUM_BYTES/2{d[15:0]}}
  - word: d
  - Loads drive memory_data_out = 0.
- load and store both high: treated as a store; memory_read = 0.
- req_valid high with load = store = 0: ignored, no stall, no issue.
- Scan: when scan = 1 and the internal cycle counter is within [SCAN_CYCLES_MIN, SCAN_CYCLES_MAX], $display CORE, state and all memory_* outputs every cycle.

Decomposition:
- Shared package/include: state encodings (IDLE = 1'b0, WAIT = 1'b1) and access-size constants (SIZE_BYTE = 0, SIZE_HALF = 1, SIZE_WORD = 2). memory_receive uses the same size constants.
- One combinational sub-module, store_align: inputs log2_bytes, addr low bits, data; outputs byte_en, replicated data, misaligned flag.
- The FSM and registers stay in memory_issue.

Test Plan:
- SB: store, log2_bytes = 0, addr = 32'h3, data = 32'h000000A5, memory_ready = 1 -> next cycle memory_write = 1, byte_en = 4'b1000, data_out = 32'hA5A5A5A5, address = 32'h3; following cycle memory_write = 0.
- SH: store, log2_bytes = 1, addr = 32'h2, data = 32'h00001234 -> byte_en = 4'b1100, data_out = 32'h12341234.
- LW with memory_ready held 0 for 3 cycles, addr = 32'h8 -> memory_read = 1, address = 32'h8 stable 3 cycles, issue_stall = 1 those cycles. Then ready = 1 -> stall = 0; receive_log2_bytes = 2, receive_unsigned = 0, receive_address = 32'h8.
- Misaligned LH at addr = 32'h1 -> misaligned = 1 for 1 cycle, misaligned_address = 32'h1, memory_read stays 0.
- Back-to-back: LBU addr = 32'h4 then SW addr = 32'hC data = 32'hDEADBEEF, ready = 1 -> consecutive cycles show read (byte_en 4'b0001) then write (byte_en 4'b1111, data 32'hDEADBEEF), no stall.
- Reset asserted while in WAIT with ready = 0 -> next posedge: memory_read = memory_write = 0, issue_stall = 0, receive_* = 0. After reset drops, the old request is not re-issued.
